// File: rtl/led_line_shifter.sv
// HUB75 line shifter: fetches one row of pixel words from framebuffer RAM and
// shifts the selected bit-plane into the column drivers, then signals line done.
module led_line_shifter #(
    parameter int unsigned COLS  = 64,
    parameter int unsigned COL_W = 6,
    parameter int unsigned ROW_W = 5,
    parameter int unsigned BPC   = 4
) (
    input  logic                         clk_25MHz,
    input  logic                         rst,
    input  logic                         next_line_begin,
    input  logic [ROW_W-1:0]             next_line_addr,
    input  logic [3:0]                   next_line_pwm,
    input  logic                         base_addr,
    input  logic                         ram_en,
    output logic                         next_line_done,
    output logic                         ram_rd,
    output logic [1+ROW_W+COL_W-1:0]     ram_addr,
    input  logic [6*BPC-1:0]             ram_data,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic                         r2,
    output logic                         g2,
    output logic                         b2,
    output logic                         sclk
);

    localparam int unsigned PWM_W = 4;
    localparam int unsigned SEL_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned NCH   = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_DRIVE = 3'd3,
        S_CLK   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ROW_W-1:0]   row_q;
    logic [PWM_W-1:0]   pwm_q;
    logic               page_q;
    logic [COL_W-1:0]   col_q;
    logic               last_col;
    logic               sclk_d;
    logic               done_d;
    logic [BPC-1:0]     chan [NCH];
    logic [NCH-1:0]     bits_c;

    assign last_col = (col_q == COL_W'(COLS - 1));

    // State register
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (next_line_begin) state_next = S_FETCH;
            S_FETCH: if (ram_en) state_next = S_WAIT;
            S_WAIT:  state_next = S_DRIVE;
            S_DRIVE: state_next = S_CLK;
            S_CLK:   state_next = last_col ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode; sclk and done are decoded from the next state so their flops track the state exactly
    always_comb begin
        ram_rd   = 1'b0;
        ram_addr = '0;
        sclk_d   = 1'b0;
        done_d   = 1'b0;
        if (state == S_FETCH && ram_en) begin
            ram_rd   = 1'b1;
            ram_addr = {page_q, row_q, col_q};
        end
        sclk_d = (state_next == S_CLK);
        done_d = (state_next == S_DONE);
    end

    // Word is {R_top, G_top, B_top, R_bot, G_bot, B_bot}; out-of-range planes blank the line
    always_comb begin
        bits_c = '0;
        for (int i = 0; i < NCH; i++) begin
            chan[i] = ram_data[(NCH-1-i)*BPC +: BPC];
        end
        if (32'(pwm_q) < BPC) begin
            for (int i = 0; i < NCH; i++) begin
                bits_c[i] = chan[i][SEL_W'(pwm_q)];
            end
        end
    end

    // Captured line parameters, column counter and registered panel outputs
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            row_q          <= '0;
            pwm_q          <= '0;
            page_q         <= 1'b0;
            col_q          <= '0;
            sclk           <= 1'b0;
            next_line_done <= 1'b0;
            {r1, g1, b1, r2, g2, b2} <= '0;
        end else begin
            sclk           <= sclk_d;
            next_line_done <= done_d;
            if (state == S_IDLE && next_line_begin) begin
                row_q  <= next_line_addr;
                pwm_q  <= next_line_pwm;
                page_q <= base_addr;
                col_q  <= '0;
            end
            if (state == S_WAIT) begin
                {b2, g2, r2, b1, g1, r1} <= bits_c;
            end
            if (state == S_CLK && !last_col) begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

endmodule
